// File: rtl/noc_ni_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_ni_pkg : flit geometry and flit record for the local NI.         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package noc_ni_pkg;

    localparam int FLIT_W    = 16;
    localparam int PAYLOAD_W = 12;
    localparam int COORD_W   = 2;

    typedef struct packed {
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic flit_t make_flit(input logic [2*COORD_W-1:0] dest,
                                        input logic [PAYLOAD_W-1:0] data);
        flit_t f;
        f.dest_x  = dest[2*COORD_W-1:COORD_W];
        f.dest_y  = dest[COORD_W-1:0];
        f.payload = data;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_sync_fifo : first-word-fall-through FIFO, DEPTH a power of 2.    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module noc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW:0]    wr_ptr_q;
    logic [c_AW:0]    rd_ptr_q;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                       (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign data_o    = mem_q[rd_ptr_q[c_AW-1:0]];
    assign w_do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is still legal when a pop frees the slot this cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[c_AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/noc_local_ni.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_local_ni : core <-> router local-port NI with credit flow ctrl.  |
// | Option NOC_NI_MISROUTE_CHECK_EN adds misroute_o and drops foreign    |
// | flits.  Revision : 1.0                                               |
// +----------------------------------------------------------------------+
module noc_local_ni
    import noc_ni_pkg::*;
#(
    parameter int CREDITS   = 4,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inj_valid_i,
    output logic                 inj_ready_o,
    input  logic [3:0]           inj_dest_i,
    input  logic [PAYLOAD_W-1:0] inj_data_i,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 valid_o,
    input  logic                 credit_i,
    input  logic [FLIT_W-1:0]    flit_i,
    input  logic                 valid_i,
    output logic                 credit_o,
    output logic                 ej_valid_o,
    input  logic                 ej_ready_i,
    output logic [FLIT_W-1:0]    ej_flit_o,
    output logic                 overflow_o
`ifdef NOC_NI_MISROUTE_CHECK_EN
    ,
    output logic                 misroute_o
`endif
);

    localparam int                 c_CNT_W   = $clog2(CREDITS + 1);
    localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(CREDITS);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               valid_q;
    logic [FLIT_W-1:0]  flit_q;
    logic               credit_q, credit_d;
    logic               overflow_q;

    logic               w_inj_full, w_inj_empty;
    logic [FLIT_W-1:0]  w_inj_head;
    logic               w_accept, w_send, w_bypass;
    flit_t              w_req;
    logic [FLIT_W-1:0]  w_send_flit;

    assign inj_ready_o = !w_inj_full && !rst;
    assign w_accept    = inj_valid_i && inj_ready_o;
    assign w_req       = make_flit(inj_dest_i, inj_data_i);
    // An empty FIFO lets the incoming request go straight out, giving one-cycle latency.
    assign w_send      = (cnt_q != '0) && (!w_inj_empty || w_accept);
    assign w_bypass    = w_send && w_inj_empty;
    assign w_send_flit = w_inj_empty ? w_req : w_inj_head;

    noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_accept && !w_bypass),
        .data_i  (w_req),
        .pop_i   (w_send && !w_inj_empty),
        .data_o  (w_inj_head),
        .full_o  (w_inj_full),
        .empty_o (w_inj_empty)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (credit_i && w_send) begin
            cnt_d = cnt_q;
        end else if (credit_i) begin
            if (cnt_q != c_CREDITS) cnt_d = cnt_q + 1'b1;
        end else if (w_send) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    logic w_ej_full, w_ej_empty, w_ej_pop, w_ej_push, w_drop;

    assign ej_valid_o = !w_ej_empty;
    assign w_ej_pop   = ej_valid_o && ej_ready_i;

`ifdef NOC_NI_MISROUTE_CHECK_EN
    localparam logic [3:0] c_MY_NODE = {2'(MY_X), 2'(MY_Y)};
    localparam int         c_OWE_W   = $clog2(EJ_DEPTH + 2) + 1;

    logic               w_misroute;
    logic               misroute_q;
    logic [c_OWE_W-1:0] owed_q, owed_d;
    logic [c_OWE_W-1:0] w_demand;

    assign w_misroute = valid_i && (flit_i[15:12] != c_MY_NODE);
    assign w_ej_push  = valid_i && !w_misroute;
    assign misroute_o = misroute_q;
    // A pop and a misroute in one cycle owe two credits; the spare one is paid next cycle.
    assign w_demand   = owed_q + c_OWE_W'(w_ej_pop) + c_OWE_W'(w_misroute);
    assign credit_d   = (w_demand != '0);
    assign owed_d     = w_demand - c_OWE_W'(credit_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misroute_q <= 1'b0;
            owed_q     <= '0;
        end else begin
            misroute_q <= misroute_q | w_misroute;
            owed_q     <= owed_d;
        end
    end
`else
    assign w_ej_push = valid_i;
    assign credit_d  = w_ej_pop;
`endif

    assign w_drop = w_ej_push && w_ej_full && !w_ej_pop;

    noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_ej_push),
        .data_i  (flit_i),
        .pop_i   (w_ej_pop),
        .data_o  (ej_flit_o),
        .full_o  (w_ej_full),
        .empty_o (w_ej_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= c_CREDITS;
            valid_q    <= 1'b0;
            flit_q     <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            valid_q    <= w_send;
            if (w_send) flit_q <= w_send_flit;
            credit_q   <= credit_d;
            overflow_q <= overflow_q | w_drop;
        end
    end

    assign valid_o    = valid_q;
    assign flit_o     = flit_q;
    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire
